// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared FSM states, SDI config-word fields and frame constants (ADC_SEQ_AVG4_EN selects 4-frame averaging)
package adc_seq_pkg;
  typedef enum logic [2:0] {IDLE, CONVST, CONV_WAIT, SHIFT, GAP} state_t;
  localparam logic SD_BIT = 1'b1;
  localparam logic UNI_BIT = 1'b1;
  localparam logic SLP_BIT = 1'b0;
  localparam int FRAME_BITS = 12;
`ifdef ADC_SEQ_AVG4_EN
  localparam int AVG_REPS = 4;
`else
  localparam int AVG_REPS = 1;
`endif
  // MSB is the first bit onto SDI
  function automatic logic [5:0] cfg_word(input logic [2:0] ch);
    return {SD_BIT, ch[0], ch[2], ch[1], UNI_BIT, SLP_BIT};
  endfunction
endpackage

// File: rtl/adc_seq_spi_shifter.sv
// adc_seq_spi_shifter: SCK divider with 12-bit SDI/SDO shift, go/done handshake
module adc_seq_spi_shifter
  import adc_seq_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [5:0]  cfg,
  input  logic        dout,
  output logic        sclk,
  output logic        din,
  output logic        done,
  output logic [11:0] data
);
  logic        active;
  logic [7:0]  div;
  logic [3:0]  bit_cnt;
  logic [11:0] tx;
  logic        tick;
  assign tick = active && div == 8'(CLK_DIV - 1);
  assign done = tick && sclk && bit_cnt == 4'(FRAME_BITS - 1);
  assign din = tx[11];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      active <= 1'b0;
      sclk <= 1'b0;
      div <= '0;
      bit_cnt <= '0;
      tx <= '0;
      data <= '0;
    end else if (go) begin
      active <= 1'b1;
      sclk <= 1'b0;
      div <= '0;
      bit_cnt <= '0;
      tx <= {cfg, 6'b0};
    end else if (active) begin
      div <= tick ? 8'd0 : div + 8'd1;
      // SDO is sampled and SDI advanced on the edge that drops SCK
      if (tick) begin
        sclk <= ~sclk;
        if (sclk) begin
          data <= {data[10:0], dout};
          tx <= {tx[10:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          active <= !done;
        end
      end
    end
endmodule

// File: rtl/adc_ltc2308_sequencer.sv
// adc_ltc2308_sequencer: LTC2308 channel scanner with result strobe and result file (ADC_SEQ_AVG4_EN: 4-sample averaging)
module adc_ltc2308_sequencer
  import adc_seq_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CONV_CYCLES = 170,
  parameter int CONVST_HI = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        auto_run,
  input  logic [7:0]  ch_mask,
  output logic        busy,
  output logic        result_valid,
  output logic [2:0]  result_ch,
  output logic [11:0] result_data,
  output logic        sweep_done,
  input  logic [2:0]  rd_ch,
  output logic [11:0] rd_data,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout
);
  localparam logic [1:0] LAST_REP = 2'(AVG_REPS - 1);
  // next set bit above cur, wrapping to the lowest set bit
  function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [7:0] m);
    logic [2:0] r;
    r = cur;
    for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
    for (int i = 7; i >= 0; i--) if (m[i] && i > int'(cur)) r = 3'(i);
    return r;
  endfunction
  state_t      state, state_n;
  logic [15:0] cnt;
  logic        go, done, prime, swept, gap0, gap_end, last_ch;
  logic [2:0]  cfg_ch, res_ch;
  logic [1:0]  cfg_rep, res_rep;
  logic [11:0] rx;
  logic [11:0] file_q [8];
  adc_seq_spi_shifter #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk(clk), .reset(reset), .go(go), .cfg(cfg_word(cfg_ch)), .dout(adc_dout),
    .sclk(adc_sclk), .din(adc_din), .done(done), .data(rx)
  );
  assign busy = state != IDLE;
  assign adc_cs_n = state == CONVST;
  assign gap0 = state == GAP && cnt == 16'd0;
  assign gap_end = state == GAP && cnt == 16'(GAP_CYCLES - 1);
  assign last_ch = next_ch(res_ch, ch_mask) <= res_ch;
  assign result_valid = gap0 && !prime && res_rep == LAST_REP;
  assign sweep_done = result_valid && last_ch;
  assign result_ch = res_ch;
  assign rd_data = file_q[rd_ch];
`ifdef ADC_SEQ_AVG4_EN
  logic [13:0] sum_q, sum_n;
  assign sum_n = (res_rep == 2'd0 ? 14'd0 : sum_q) + 14'(rx);
  assign result_data = sum_n[13:2];
  always_ff @(posedge clk or posedge reset)
    if (reset) sum_q <= '0;
    else if (gap0 && !prime) sum_q <= sum_n;
`else
  assign result_data = rx;
`endif
  always_comb begin
    state_n = state;
    go = 1'b0;
    case (state)
      IDLE:      if ((start || auto_run) && |ch_mask) state_n = CONVST;
      CONVST:    if (cnt == 16'(CONVST_HI - 1)) state_n = CONV_WAIT;
      CONV_WAIT: if (cnt == 16'(CONV_CYCLES - 1)) begin
        go = 1'b1;
        state_n = SHIFT;
      end
      SHIFT:     if (done) state_n = GAP;
      GAP:       if (gap_end) state_n = (ch_mask == 8'd0 || (swept && !auto_run)) ? IDLE : CONVST;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      prime <= 1'b1;
      swept <= 1'b0;
      cfg_ch <= '0;
      res_ch <= '0;
      cfg_rep <= '0;
      res_rep <= '0;
      file_q <= '{default: '0};
    end else begin
      state <= state_n;
      cnt <= state_n != state ? 16'd0 : cnt + 16'd1;
      if (state == IDLE && state_n == CONVST) begin
        cfg_ch <= next_ch(3'd7, ch_mask);
        cfg_rep <= '0;
        prime <= 1'b1;
      end
      if (gap0) swept <= sweep_done;
      if (result_valid) file_q[res_ch] <= result_data;
      // config shifted this frame becomes the channel read back next frame
      if (gap_end) begin
        prime <= 1'b0;
        res_ch <= cfg_ch;
        res_rep <= cfg_rep;
        cfg_rep <= cfg_rep == LAST_REP ? 2'd0 : cfg_rep + 2'd1;
        if (cfg_rep == LAST_REP) cfg_ch <= next_ch(cfg_ch, ch_mask);
      end
    end
endmodule
